// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding,
// default vectors and the next-PC select encoding.
package pc_pkg;

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_TRAP   = 3'd3,
    SEL_MRET   = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority selection and redirect misalignment check; purely combinational.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int N   = 32,
  parameter int INC = 4
) (
  input  logic [1:0]   state,
  input  logic         trapReq,
  input  logic         branchTaken,
  input  logic [N-1:0] branchTarget,
  input  logic         mretReq,
  input  logic         halt,
  input  logic         stall,
  output pc_sel_e      sel,
  output logic         trap_misaligned
);

  // With INC=1 the mask is zero, so no target can be misaligned.
  localparam logic [N-1:0] ALIGN_MASK = N'(INC - 1);

  logic target_misaligned_s;

  assign target_misaligned_s = ((branchTarget & ALIGN_MASK) != {N{1'b0}});

  // Priority encoder over the request inputs, qualified by the current state.
  always_comb begin
    sel             = SEL_HOLD;
    trap_misaligned = 1'b0;
    case (state)
      RUN: begin
        if (trapReq) begin
          sel             = SEL_TRAP;
          trap_misaligned = 1'b0;
        end else if (branchTaken && target_misaligned_s) begin
          sel             = SEL_TRAP;
          trap_misaligned = 1'b1;
        end else if (mretReq) begin
          sel = SEL_MRET;
        end else if (branchTaken) begin
          sel = SEL_BRANCH;
        end else if (halt || stall) begin
          sel = SEL_HOLD;
        end else begin
          sel = SEL_SEQ;
        end
      end
      HALTED: begin
        if (trapReq) begin
          sel = SEL_TRAP;
        end else begin
          sel = SEL_HOLD;
        end
      end
      default: begin
        sel             = SEL_HOLD;
        trap_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register, BOOT/RUN/HALTED control,
// trap entry/return with saved exception PC.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          N            = 32,
  parameter int          INC          = 4,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branchTaken,
  input  logic [N-1:0] branchTarget,
  input  logic         trapReq,
  input  logic         mretReq,
  input  logic         halt,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic [N-1:0] pcPlusInc,
  output logic [N-1:0] epc,
  output logic         misaligned,
  output logic         fetchValid,
  output logic [1:0]   state
);

  localparam logic [N-1:0] RESET_PC = N'(RESET_VECTOR);
  localparam logic [N-1:0] TRAP_PC  = N'(TRAP_VECTOR);
  localparam logic [N-1:0] INC_N    = N'(INC);

  logic [1:0]   state_r;
  logic [1:0]   state_next_s;
  logic [N-1:0] pc_r;
  logic [N-1:0] pc_next_s;
  logic [N-1:0] epc_r;
  logic         misaligned_r;
  logic [N-1:0] pc_plus_inc_s;
  logic         fetch_valid_s;
  pc_sel_e      sel_s;
  logic         trap_misaligned_s;

  pc_next_sel #(
    .N   (N),
    .INC (INC)
  ) u_next_sel (
    .state           (state_r),
    .trapReq         (trapReq),
    .branchTaken     (branchTaken),
    .branchTarget    (branchTarget),
    .mretReq         (mretReq),
    .halt            (halt),
    .stall           (stall),
    .sel             (sel_s),
    .trap_misaligned (trap_misaligned_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; halt only takes effect when no redirect was selected.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BOOT: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (halt && (sel_s == SEL_HOLD)) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      HALTED: begin
        if (trapReq || resume) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: begin
        state_next_s = BOOT;
      end
    endcase
  end

  // Output logic derived from the registered state and PC.
  always_comb begin
    fetch_valid_s = (state_r == RUN);
    pc_plus_inc_s = pc_r + INC_N;
  end

  // Next-PC multiplexer.
  always_comb begin
    pc_next_s = pc_r;
    case (sel_s)
      SEL_SEQ:    pc_next_s = pc_plus_inc_s;
      SEL_HOLD:   pc_next_s = pc_r;
      SEL_BRANCH: pc_next_s = branchTarget;
      SEL_TRAP:   pc_next_s = TRAP_PC;
      SEL_MRET:   pc_next_s = epc_r;
      default:    pc_next_s = pc_r;
    endcase
  end

  // PC, exception PC and misaligned flag; the latter two change only on trap entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      epc_r        <= {N{1'b0}};
      misaligned_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (sel_s == SEL_TRAP) begin
        epc_r        <= pc_r;
        misaligned_r <= trap_misaligned_s;
      end
    end
  end

  assign pc         = pc_r;
  assign pcPlusInc  = pc_plus_inc_s;
  assign epc        = epc_r;
  assign misaligned = misaligned_r;
  assign fetchValid = fetch_valid_s;
  assign state      = state_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (N=32 main instance, N=8 wrap instance).
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branchTaken, trapReq, mretReq, halt, resume;
  logic [31:0] branchTarget;
  logic [31:0] pc, pcPlusInc, epc;
  logic        misaligned, fetchValid;
  logic [1:0]  state;

  logic        br8;
  logic [7:0]  tgt8;
  logic [7:0]  pc8, ppi8, epc8;
  logic        mis8, fv8;
  logic [1:0]  st8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .trapReq(trapReq), .mretReq(mretReq),
    .halt(halt), .resume(resume), .pc(pc), .pcPlusInc(pcPlusInc), .epc(epc),
    .misaligned(misaligned), .fetchValid(fetchValid), .state(state)
  );

  pc_unit #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .stall(1'b0), .branchTaken(br8),
    .branchTarget(tgt8), .trapReq(1'b0), .mretReq(1'b0),
    .halt(1'b0), .resume(1'b0), .pc(pc8), .pcPlusInc(ppi8), .epc(epc8),
    .misaligned(mis8), .fetchValid(fv8), .state(st8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branchTaken = 1'b0; trapReq = 1'b0; mretReq = 1'b0;
    halt = 1'b0; resume = 1'b0; branchTarget = 32'h0; br8 = 1'b0; tgt8 = 8'h0;
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp);
    checks++;
    if (pc !== exp) begin errors++; $display("FAIL %s: pc=%h expected %h", name, pc, exp); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step(); step();
    check_pc("reset_pc", 32'h0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: %0d expected 0", state); end
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL reset_fv: %b expected 0", fetchValid); end
    checks++; if (epc !== 32'h0 || misaligned !== 1'b0) begin errors++; $display("FAIL reset_epc: epc=%h mis=%b expected 0/0", epc, misaligned); end
    reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL boot_state: %0d expected 0", state); end
    step();
    check_pc("boot_hold_pc", 32'h0);
    checks++; if (state !== 2'd1 || fetchValid !== 1'b1) begin errors++; $display("FAIL run_entry: state=%0d fv=%b expected 1/1", state, fetchValid); end
    step(); check_pc("seq_4", 32'h4);
    checks++; if (pcPlusInc !== 32'h8) begin errors++; $display("FAIL pc_plus_inc: %h expected 8", pcPlusInc); end
    step(); check_pc("seq_8", 32'h8);
    step(); check_pc("seq_c", 32'hC);
  endtask

  task automatic test_branch();
    step(); check_pc("seq_10", 32'h10);
    branchTaken = 1'b1; branchTarget = 32'h40;
    step(); check_pc("branch_40", 32'h40);
    clear_inputs();
    step(); check_pc("after_branch_44", 32'h44);
    branchTaken = 1'b1; branchTarget = 32'h40; stall = 1'b1;
    step(); check_pc("branch_beats_stall", 32'h40);
    branchTaken = 1'b0;
    step(); check_pc("stall_hold", 32'h40);
    stall = 1'b0;
    step(); check_pc("after_stall_44", 32'h44);
  endtask

  task automatic test_misaligned_mret();
    branchTaken = 1'b1; branchTarget = 32'h20;
    step(); check_pc("branch_20", 32'h20);
    branchTarget = 32'h42;
    step(); check_pc("misaligned_trap", 32'h100);
    checks++; if (epc !== 32'h20 || misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_epc: epc=%h mis=%b expected 20/1", epc, misaligned); end
    clear_inputs(); mretReq = 1'b1;
    step(); check_pc("mret_20", 32'h20);
    checks++; if (misaligned !== 1'b1 || epc !== 32'h20) begin errors++; $display("FAIL mret_sticky: epc=%h mis=%b expected 20/1", epc, misaligned); end
    clear_inputs();
  endtask

  task automatic test_priority();
    branchTaken = 1'b1; branchTarget = 32'h8;
    step(); check_pc("branch_8", 32'h8);
    trapReq = 1'b1; branchTarget = 32'h40; mretReq = 1'b1;
    step(); check_pc("trap_priority", 32'h100);
    checks++; if (epc !== 32'h8 || misaligned !== 1'b0) begin errors++; $display("FAIL trap_priority_epc: epc=%h mis=%b expected 8/0", epc, misaligned); end
    clear_inputs();
  endtask

  task automatic test_halt();
    branchTaken = 1'b1; branchTarget = 32'h14;
    step(); check_pc("branch_14", 32'h14);
    clear_inputs(); halt = 1'b1;
    step(); check_pc("halt_14", 32'h14);
    checks++; if (state !== 2'd2 || fetchValid !== 1'b0) begin errors++; $display("FAIL halt_state: state=%0d fv=%b expected 2/0", state, fetchValid); end
    halt = 1'b0; branchTarget = 32'h80;
    for (int i = 0; i < 5; i++) begin
      branchTaken = (i % 2 == 0); mretReq = (i % 2 == 1); stall = 1'b1;
      step(); check_pc("halted_hold", 32'h14);
      checks++; if (fetchValid !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL halted_fv: fv=%b state=%0d expected 0/2", fetchValid, state); end
    end
    clear_inputs(); resume = 1'b1;
    step(); check_pc("resume_14", 32'h14);
    checks++; if (state !== 2'd1 || fetchValid !== 1'b1) begin errors++; $display("FAIL resume_state: state=%0d fv=%b expected 1/1", state, fetchValid); end
    resume = 1'b0;
    step(); check_pc("resume_18", 32'h18);
    halt = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40;
    step(); check_pc("halt_with_branch", 32'h40);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL halt_ignored: state=%0d expected 1", state); end
    branchTaken = 1'b0;
    step(); check_pc("halt_40", 32'h40);
    halt = 1'b0; trapReq = 1'b1;
    step(); check_pc("halted_trap", 32'h100);
    checks++; if (state !== 2'd1 || epc !== 32'h40 || misaligned !== 1'b0) begin errors++; $display("FAIL halted_trap_state: state=%0d epc=%h mis=%b expected 1/40/0", state, epc, misaligned); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    br8 = 1'b1; tgt8 = 8'hFC;
    step();
    checks++; if (pc8 !== 8'hFC || ppi8 !== 8'h00) begin errors++; $display("FAIL wrap_setup: pc=%h ppi=%h expected fc/00", pc8, ppi8); end
    br8 = 1'b0;
    step();
    checks++; if (pc8 !== 8'h00) begin errors++; $display("FAIL wrap_zero: pc=%h expected 00", pc8); end
    step();
    checks++; if (pc8 !== 8'h04) begin errors++; $display("FAIL wrap_04: pc=%h expected 04", pc8); end
  endtask

  task automatic test_async_reset();
    branchTaken = 1'b1; branchTarget = 32'h30;
    step(); check_pc("branch_30", 32'h30);
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    check_pc("async_reset_pc", 32'h0);
    checks++; if (state !== 2'd0 || fetchValid !== 1'b0 || epc !== 32'h0) begin errors++; $display("FAIL async_reset_state: state=%0d fv=%b epc=%h expected 0/0/0", state, fetchValid, epc); end
    step();
    reset = 1'b0;
    step(); check_pc("post_reset_run", 32'h0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_reset_state: %0d expected 1", state); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_misaligned_mret();
    test_priority();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
